// File: rtl/uart_rx_param.sv
// Parametrised RS232 receiver (8N1 by default) with optional parity, framing check
// and valid/ready output. Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO.
module uart_rx_param #(
  parameter int CLK_HZ     = 54_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int IW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI} state_t;

  state_t                r_state, w_next;
  logic                  r_rx_s1, r_rx_s2;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_bad;
  logic                  r_ferr, r_perr, r_ovr;
  logic                  w_rx, w_tick_half, w_tick_full, w_stop_smp, w_cnt_clr;
  logic                  w_good, w_pop;

  assign w_rx        = r_rx_s2;
  assign w_tick_half = (r_cnt == CW'(HALF - 1));
  assign w_tick_full = (r_cnt == CW'(DIV - 1));

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_stop_smp = 1'b0;
    case (r_state)
      S_IDLE:    if (!w_rx) w_next = S_START;
      S_START:   if (w_tick_half) w_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:    if (w_tick_full && r_idx == IW'(DATA_BITS - 1))
                   w_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:     if (w_tick_full) w_next = S_STOP;
      S_STOP:    if (w_tick_full) begin
                   w_stop_smp = 1'b1;
                   w_next     = w_rx ? S_IDLE : S_WAIT_HI;
                 end
      S_WAIT_HI: if (w_rx) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Counter restarts on every state entry and between data bits
  assign w_cnt_clr = (w_next != r_state) || (r_state == S_DATA && w_tick_full) ||
                     (r_state == S_IDLE) || (r_state == S_WAIT_HI);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state != S_DATA) r_idx <= '0;
      else if (w_tick_full) begin
        r_idx          <= r_idx + 1'b1;
        r_shift[r_idx] <= w_rx;
      end
      if (r_state == S_START) r_par_bad <= 1'b0;
      else if (r_state == S_PAR && w_tick_full)
        r_par_bad <= (^{r_shift, w_rx}) ^ (PARITY == 1);
    end
  end

  assign w_good = w_stop_smp & w_rx & ~r_par_bad;
  assign w_pop  = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_ferr <= w_stop_smp & ~w_rx;
      r_perr <= w_stop_smp & r_par_bad;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [AW:0]          r_count;
  logic                 w_full, w_push;

  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign w_push   = w_good & (~w_full | w_pop);
  assign rx_valid = (r_count != '0);
  assign rx_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_good & ~w_push;
      if (w_push) begin
        r_mem[r_wr] <= r_shift;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;

  assign rx_valid = r_valid;
  assign rx_data  = r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_good && (!r_valid || w_pop)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        if (w_good) r_ovr   <= 1'b1;
        if (w_pop)  r_valid <= 1'b0;
      end
    end
  end
`endif

  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at DIV=16: one 8N1 instance and one even-parity instance.
module tb_uart_rx_param;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 16;

  logic       clk = 1'b0, reset = 1'b0, rxd = 1'b1, rxd_p = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  int n_tests = 0, n_fail = 0;
  int n_ferr = 0, n_perr = 0, n_ovr = 0, p_ferr = 0, p_perr = 0, p_ovr = 0;
  logic [7:0] got[$];
  logic [7:0] gotp[$];

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .reset(reset), .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .busy(busy_p));

  always #5 clk = ~clk;

  // Record accepted bytes and flag pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid && rx_ready)     got.push_back(rx_data);
      if (rx_valid_p && rx_ready)   gotp.push_back(rx_data_p);
      if (frame_err)    n_ferr++;
      if (parity_err)   n_perr++;
      if (overrun)      n_ovr++;
      if (frame_err_p)  p_ferr++;
      if (parity_err_p) p_perr++;
      if (overrun_p)    p_ovr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_bit(input logic b, input bit on_p);
    if (on_p) rxd_p = b; else rxd = b;
    idle(DIV);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input bit on_p,
                      input bit use_par, input logic pb);
    tx_bit(1'b0, on_p);
    for (int i = 0; i < 8; i++) tx_bit(d[i], on_p);
    if (use_par) tx_bit(pb, on_p);
    tx_bit(stop, on_p);
  endtask

  initial begin
    logic [7:0] f;
    f = 8'h5A;

    // reset state
    idle(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {frame_err, parity_err, overrun}, 0);
    reset = 1'b1;
    idle(5);

    // 1: two clean 8N1 frames
    send(8'h55, 1'b1, 0, 0, 1'b0); idle(20);
    send(8'hA3, 1'b1, 0, 0, 1'b0); idle(20);
    check("t1_count", got.size(), 2);
    check("t1_b0", got[0], 8'h55);
    check("t1_b1", got[1], 8'hA3);
    check("t1_flags", n_ferr + n_perr + n_ovr, 0);
    check("t1_busy", busy, 0);

    // 2: 5-cycle glitch aborts in START
    rxd = 1'b0; idle(5); rxd = 1'b1; idle(3);
    check("t2_busy_mid", busy, 1);
    idle(20);
    check("t2_busy_end", busy, 0);
    check("t2_count", got.size(), 2);
    check("t2_flags", n_ferr + n_perr + n_ovr, 0);

    // 3: bad stop bit, line held low, then good frame
    send(8'h3C, 1'b0, 0, 0, 1'b0);
    idle(16);
    check("t3_busy_break", busy, 1);
    idle(32);
    rxd = 1'b1; idle(32);
    send(8'h81, 1'b1, 0, 0, 1'b0); idle(20);
    check("t3_ferr", n_ferr, 1);
    check("t3_count", got.size(), 3);
    check("t3_b", got[2], 8'h81);

    // 4: even parity, wrong then right parity bit
    send(8'h07, 1'b1, 1, 1, 1'b0); idle(20);
    check("t4_perr", p_perr, 1);
    check("t4_none", gotp.size(), 0);
    send(8'h07, 1'b1, 1, 1, 1'b1); idle(20);
    check("t4_count", gotp.size(), 1);
    check("t4_b", gotp[0], 8'h07);
    check("t4_perr2", p_perr, 1);
    check("t4_ferr", p_ferr + p_ovr, 0);

    // 5: consumer stalled for three frames
    rx_ready = 1'b0;
    send(8'h11, 1'b1, 0, 0, 1'b0); idle(20);
    send(8'h22, 1'b1, 0, 0, 1'b0); idle(20);
    send(8'h33, 1'b1, 0, 0, 1'b0); idle(20);
    check("t5_valid", rx_valid, 1);
    check("t5_head", rx_data, 8'h11);
`ifdef UART_RX_FIFO_EN
    check("t5_ovr", n_ovr, 0);
    rx_ready = 1'b1; idle(6);
    check("t5_count", got.size(), 6);
    check("t5_p0", got[3], 8'h11);
    check("t5_p1", got[4], 8'h22);
    check("t5_p2", got[5], 8'h33);
`else
    check("t5_ovr", n_ovr, 2);
    rx_ready = 1'b1; idle(6);
    check("t5_count", got.size(), 4);
    check("t5_p0", got[3], 8'h11);
`endif
    check("t5_empty", rx_valid, 0);

    // 6: reset mid-frame flushes stored data and partial frame
    rx_ready = 1'b0;
    send(8'h99, 1'b1, 0, 0, 1'b0); idle(20);
    check("t6_held", rx_valid, 1);
    tx_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) tx_bit(f[i], 0);
    rxd = f[4]; idle(8);
    check("t6_busy_pre", busy, 1);
    reset = 1'b0; rxd = 1'b1; idle(2);
    check("t6_valid", rx_valid, 0);
    check("t6_data", rx_data, 0);
    check("t6_busy", busy, 0);
    check("t6_flags", {frame_err, parity_err, overrun}, 0);
    idle(40);
    reset = 1'b1; idle(5);
    check("t6_still_empty", rx_valid, 0);
    rx_ready = 1'b1;
    send(8'h5A, 1'b1, 0, 0, 1'b0); idle(20);
`ifdef UART_RX_FIFO_EN
    check("t6_count", got.size(), 7);
`else
    check("t6_count", got.size(), 5);
`endif
    check("t6_b", got[got.size()-1], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
